// File: rtl/phy_mdio_pkg.sv
// Shared definitions for the Clause-22 PHY link monitor: FSM states, MDIO frame fields, frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package phy_mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        PREAMBLE,
        CMD,
        TA,
        DATA,
        DONE,
        WAIT
    } state_t;

    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;

    localparam logic [4:0] REG_BMSR      = 5'd1;
    localparam int         BMSR_LINK_BIT = 2;

    // Frame geometry in MDC periods: 32 preamble, 14 command, 2 turnaround, 16 data.
    localparam int FRAME_BITS = 64;
    localparam int PRE_BITS   = 32;
    localparam int TA_START   = 46;

endpackage

// File: rtl/phy_link_monitor_mdc_gen.sv
// MDC divider: toggles mdc every MDC_DIV clk while enabled, with single-cycle rise/fall ticks.
// Latency: first rise MDC_DIV clk after en goes high; ticks are asserted in the clk before mdc changes.
// Backpressure: none; dropping en clears the divider and forces mdc low on the next clk.
//
// Ports: clk, rst (async, active-high), en (run divider), mdc (registered clock out),
//        rise/fall (high in the cycle whose closing edge raises/lowers mdc).
module mdc_gen #(
    parameter int MDC_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam int            CW       = $clog2(MDC_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(MDC_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          mdc_q;
    logic          half_done;

    assign half_done = en && (cnt_q == DIV_LAST);
    assign rise      = half_done && !mdc_q;
    assign fall      = half_done && mdc_q;
    assign mdc       = mdc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else if (half_done) begin
            cnt_q <= '0;
            mdc_q <= !mdc_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/phy_link_monitor.sv
// PHY link monitor: after PHY reset release and a settle delay, polls BMSR over MDIO and reports link/status.
// Latency: first frame SETTLE_CYCLES+1 clk after phy_rst_n rises; status_valid 128*MDC_DIV+1 clk after frame start.
// Backpressure: none; phy_rst_n low aborts any frame on the next clk and suppresses status_valid.
//
// Ports: clk, rst (async, active-high), phy_rst_n (PHY held in reset when low), mdio_i (pad input),
//        mdc/mdio_o/mdio_oe (MDIO master pins), link_up/status (last BMSR read),
//        status_valid (one-cycle update pulse), busy (frame in progress).
module phy_link_monitor
    import phy_mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR      = 5'd1,
    parameter int         MDC_DIV       = 20,
    parameter int         SETTLE_CYCLES = 1000,
    parameter int         POLL_CYCLES   = 125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_rst_n,
    input  logic        mdio_i,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        link_up,
    output logic [15:0] status,
    output logic        status_valid,
    output logic        busy
);

    localparam logic [13:0] CMD_WORD    = {MDIO_ST, MDIO_OP_READ, PHY_ADDR, REG_BMSR};
    localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0] POLL_LAST   = 24'(POLL_CYCLES - 1);
    localparam logic [5:0]  PRE_LAST    = 6'(PRE_BITS - 1);
    localparam logic [5:0]  CMD_LAST    = 6'(TA_START - 1);
    localparam logic [5:0]  TA_LAST     = 6'(TA_START + 1);
    localparam logic [5:0]  BIT_LAST    = 6'(FRAME_BITS - 1);

    state_t      state_q, state_d;
    logic [5:0]  bit_q, bit_d;
    logic [23:0] cnt_q, cnt_d;
    logic [13:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        link_q, link_d;
    logic [15:0] status_q, status_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic        mdc_en;
    logic        mdc_rise;
    logic        mdc_fall;

    // Gating with phy_rst_n lets an abort clear mdc on the same edge the FSM drops to IDLE.
    assign mdc_en = busy_q && phy_rst_n;

    mdc_gen #(
        .MDC_DIV (MDC_DIV)
    ) u_mdc_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (mdc_en),
        .mdc  (mdc),
        .rise (mdc_rise),
        .fall (mdc_fall)
    );

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        link_d    = link_q;
        status_d  = status_q;
        valid_d   = 1'b0;

        if (!phy_rst_n) begin
            state_d   = IDLE;
            bit_d     = '0;
            cnt_d     = '0;
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
            link_d    = 1'b0;
            status_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
                SETTLE, WAIT: begin
                    if (cnt_q == ((state_q == SETTLE) ? SETTLE_LAST : POLL_LAST)) begin
                        // Frame start: mdc is still low, so bit 0 of the preamble goes out now.
                        state_d   = PREAMBLE;
                        cnt_d     = '0;
                        bit_d     = '0;
                        tx_d      = CMD_WORD;
                        mdio_o_d  = 1'b1;
                        mdio_oe_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                PREAMBLE: begin
                    if (mdc_fall) begin
                        bit_d = bit_q + 6'd1;
                        if (bit_q == PRE_LAST) begin
                            state_d  = CMD;
                            mdio_o_d = tx_q[13];
                            tx_d     = {tx_q[12:0], 1'b0};
                        end
                    end
                end
                CMD: begin
                    if (mdc_fall) begin
                        bit_d = bit_q + 6'd1;
                        if (bit_q == CMD_LAST) begin
                            // Release the line for turnaround; it stays released through DATA.
                            state_d   = TA;
                            mdio_o_d  = 1'b1;
                            mdio_oe_d = 1'b0;
                        end else begin
                            mdio_o_d = tx_q[13];
                            tx_d     = {tx_q[12:0], 1'b0};
                        end
                    end
                end
                TA: begin
                    if (mdc_fall) begin
                        bit_d = bit_q + 6'd1;
                        if (bit_q == TA_LAST) begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (mdc_rise) begin
                        rx_d = {rx_q[14:0], mdio_i};
                    end
                    if (mdc_fall) begin
                        if (bit_q == BIT_LAST) begin
                            state_d = DONE;
                        end else begin
                            bit_d = bit_q + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state_d  = WAIT;
                    cnt_d    = '0;
                    bit_d    = '0;
                    status_d = rx_q;
                    link_d   = rx_q[BMSR_LINK_BIT];
                    valid_d  = 1'b1;
                end
            endcase
        end

        busy_d = (state_d == PREAMBLE) || (state_d == CMD) ||
                 (state_d == TA) || (state_d == DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            cnt_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
            link_q    <= 1'b0;
            status_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
            link_q    <= link_d;
            status_q  <= status_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign mdio_o       = mdio_o_q;
    assign mdio_oe      = mdio_oe_q;
    assign link_up      = link_q;
    assign status       = status_q;
    assign status_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_phy_link_monitor.sv
// Directed bench for phy_link_monitor with a clk-sampled PHY model on MDIO.
// Latency: MDC_DIV=4, SETTLE_CYCLES=16, POLL_CYCLES=40 keep frames at 512 clk.
// Backpressure: n/a.
module tb_phy_link_monitor;

    localparam int POLL = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        phy_rst_n = 1'b0;
    logic        mdio_i = 1'b1;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        link_up;
    logic [15:0] status;
    logic        status_valid;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // PHY model / monitor state
    int          k = 0;
    int          start_cyc = 0;
    int          n_starts = 0;
    int          sv_count = 0;
    int          sv_cyc = 0;
    int          oe_viol = 0;
    logic        rec_o [64];
    logic        rec_oe[64];
    logic [15:0] phy_data = 16'h0000;
    logic        mdc_p = 1'b0;
    logic        busy_p = 1'b0;

    phy_link_monitor #(
        .PHY_ADDR      (5'd1),
        .MDC_DIV       (4),
        .SETTLE_CYCLES (16),
        .POLL_CYCLES   (POLL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .phy_rst_n    (phy_rst_n),
        .mdio_i       (mdio_i),
        .mdc          (mdc),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .link_up      (link_up),
        .status       (status),
        .status_valid (status_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PHY model: k = MDC falls since frame start = current bit index. Drives mdio_i on the
    // negedge after a fall so it is stable at the next MDC rise. TA is Z then 0 (Z seen as X).
    initial begin
        forever begin
            @(negedge clk);
            if (busy && !busy_p) begin
                k = 0;
                start_cyc = cyc;
                n_starts++;
            end
            if (mdc && !mdc_p && k < 64) begin
                rec_o[k]  = mdio_o;
                rec_oe[k] = mdio_oe;
            end
            if (!mdc && mdc_p) k++;
            if (busy && k >= 46 && mdio_oe) oe_viol++;
            if (status_valid) begin
                sv_count++;
                sv_cyc = cyc;
            end
            if (busy && k == 46)                mdio_i = 1'bx;
            else if (busy && k == 47)           mdio_i = 1'b0;
            else if (busy && k >= 48 && k < 64) mdio_i = phy_data[63 - k];
            else                                mdio_i = 1'b1;
            mdc_p  = mdc;
            busy_p = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want summary");
        $fatal(1);
    end

    task automatic wait_start(input int n0, input string name);
        int b = 0;
        while (n_starts == n0 && b < 2000) begin
            @(posedge clk); #1;
            b++;
        end
        vectors++;
        if (n_starts == n0) begin
            $display("FAIL %s: no frame start within 2000 clk", name);
            miscompares++;
        end
    endtask

    task automatic wait_sv(input int s0, input string name);
        int b = 0;
        while (sv_count == s0 && b < 2000) begin
            @(posedge clk); #1;
            b++;
        end
        vectors++;
        if (sv_count == s0) begin
            $display("FAIL %s: no status_valid within 2000 clk", name);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({mdc, mdio_o, mdio_oe, busy, link_up, status_valid} !== 6'b010000) begin
            $display("FAIL rst_async_outs got %b want 010000", {mdc, mdio_o, mdio_oe, busy, link_up, status_valid});
            miscompares++;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        vectors++;
        if ({mdc, mdio_o, mdio_oe, busy, link_up, status_valid} !== 6'b010000) begin
            $display("FAIL idle_outs got %b want 010000", {mdc, mdio_o, mdio_oe, busy, link_up, status_valid});
            miscompares++;
        end
        vectors++;
        if (status !== 16'h0000) begin
            $display("FAIL idle_status got %h want 0000", status);
            miscompares++;
        end
        vectors++;
        if (n_starts !== 0) begin
            $display("FAIL idle_no_frame got %0d starts want 0", n_starts);
            miscompares++;
        end
    endtask

    task automatic test_first_read();
        int          c0, s0, n0;
        logic [45:0] got_tx;
        logic [63:0] got_oe;
        phy_data = 16'h782D;
        s0 = sv_count;
        n0 = n_starts;
        @(posedge clk); #1;
        phy_rst_n = 1'b1;
        c0 = cyc;
        wait_start(n0, "first_start");
        vectors++;
        if (start_cyc - c0 !== 17) begin
            $display("FAIL first_start_delay got %0d want 17", start_cyc - c0);
            miscompares++;
        end
        wait_sv(s0, "first_sv");
        for (int i = 0; i < 46; i++) got_tx[45 - i] = rec_o[i];
        for (int i = 0; i < 64; i++) got_oe[63 - i] = rec_oe[i];
        vectors++;
        if (got_tx !== {32'hFFFF_FFFF, 14'b01_10_00001_00001}) begin
            $display("FAIL first_tx_bits got %b want %b", got_tx, {32'hFFFF_FFFF, 14'b01_10_00001_00001});
            miscompares++;
        end
        vectors++;
        if (got_oe !== 64'hFFFF_FFFF_FFFC_0000) begin
            $display("FAIL first_oe_bits got %h want fffffffffffc0000", got_oe);
            miscompares++;
        end
        vectors++;
        if (status !== 16'h782D || link_up !== 1'b1) begin
            $display("FAIL first_status got %h/%b want 782d/1", status, link_up);
            miscompares++;
        end
        vectors++;
        if (sv_cyc - start_cyc !== 513) begin
            $display("FAIL first_sv_latency got %0d want 513", sv_cyc - start_cyc);
            miscompares++;
        end
        repeat (2) @(posedge clk); #1;
        vectors++;
        if (sv_count - s0 !== 1 || busy !== 1'b0) begin
            $display("FAIL first_sv_pulse got %0d pulses busy=%b want 1 busy=0", sv_count - s0, busy);
            miscompares++;
        end
    endtask

    task automatic test_link_down();
        int s0, n0, prev_start;
        s0 = sv_count;
        n0 = n_starts;
        prev_start = start_cyc;
        phy_data = 16'h7809;
        wait_start(n0, "down_start");
        vectors++;
        if (start_cyc - prev_start !== 513 + POLL) begin
            $display("FAIL poll_spacing got %0d want %0d", start_cyc - prev_start, 513 + POLL);
            miscompares++;
        end
        wait_sv(s0, "down_sv");
        vectors++;
        if (status !== 16'h7809 || link_up !== 1'b0) begin
            $display("FAIL down_status got %h/%b want 7809/0", status, link_up);
            miscompares++;
        end
        vectors++;
        if (sv_cyc - start_cyc !== 513) begin
            $display("FAIL down_sv_latency got %0d want 513", sv_cyc - start_cyc);
            miscompares++;
        end
    endtask

    task automatic test_turnaround();
        int          s0;
        logic [63:0] got_oe;
        s0 = sv_count;
        phy_data = 16'h0004;
        wait_sv(s0, "ta_sv");
        for (int i = 0; i < 64; i++) got_oe[63 - i] = rec_oe[i];
        vectors++;
        if (status !== 16'h0004 || link_up !== 1'b1) begin
            $display("FAIL ta_status got %h/%b want 0004/1", status, link_up);
            miscompares++;
        end
        vectors++;
        if (got_oe !== 64'hFFFF_FFFF_FFFC_0000) begin
            $display("FAIL ta_oe_bits got %h want fffffffffffc0000", got_oe);
            miscompares++;
        end
        vectors++;
        if (oe_viol !== 0) begin
            $display("FAIL ta_oe_released got %0d driven clk want 0", oe_viol);
            miscompares++;
        end
    endtask

    task automatic test_abort();
        int c0, s0, n0, b;
        phy_data = 16'h796D;
        n0 = n_starts;
        wait_start(n0, "abort_start");
        b = 0;
        while (k != 53 && b < 1000) begin
            @(posedge clk); #1;
            b++;
        end
        vectors++;
        if (k != 53) begin
            $display("FAIL abort_reach_bit got %0d want 53", k);
            miscompares++;
        end
        s0 = sv_count;
        phy_rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({mdc, mdio_o, mdio_oe, busy, link_up} !== 5'b01000) begin
            $display("FAIL abort_outs got %b want 01000", {mdc, mdio_o, mdio_oe, busy, link_up});
            miscompares++;
        end
        vectors++;
        if (status !== 16'h0000) begin
            $display("FAIL abort_status got %h want 0000", status);
            miscompares++;
        end
        repeat (600) @(posedge clk); #1;
        vectors++;
        if (sv_count !== s0) begin
            $display("FAIL abort_no_sv got %0d pulses want 0", sv_count - s0);
            miscompares++;
        end
        s0 = sv_count;
        n0 = n_starts;
        phy_rst_n = 1'b1;
        c0 = cyc;
        wait_start(n0, "abort_restart");
        vectors++;
        if (start_cyc - c0 !== 17) begin
            $display("FAIL abort_resettle got %0d want 17", start_cyc - c0);
            miscompares++;
        end
        wait_sv(s0, "abort_sv");
        vectors++;
        if (status !== 16'h796D || link_up !== 1'b1) begin
            $display("FAIL abort_fresh_status got %h/%b want 796d/1", status, link_up);
            miscompares++;
        end
    endtask

    task automatic test_async_rst();
        repeat (5) @(posedge clk);
        #3;
        vectors++;
        if (link_up !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL wait_pre_rst got link=%b busy=%b want 1/0", link_up, busy);
            miscompares++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({mdc, mdio_o, mdio_oe, busy, link_up, status_valid} !== 6'b010000) begin
            $display("FAIL async_rst_outs got %b want 010000", {mdc, mdio_o, mdio_oe, busy, link_up, status_valid});
            miscompares++;
        end
        vectors++;
        if (status !== 16'h0000) begin
            $display("FAIL async_rst_status got %h want 0000", status);
            miscompares++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_link_down();
        test_turnaround();
        test_abort();
        test_async_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
